// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT core.
// Drives sample RAM writes (bit-reversed), butterfly issue with operand and
// twiddle addressing, a fixed-latency writeback pipeline, and natural-order
// result readout. Carries no sample data itself.
module fft_seq_ctrl #(
    parameter int LOG2N  = 3,
    parameter int BF_LAT = 2,
    localparam int TW_W  = (LOG2N > 2) ? LOG2N - 1 : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic             bf_en,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_idx,
    output logic             wb_en,
    output logic [LOG2N-1:0] wb_addr_a,
    output logic [LOG2N-1:0] wb_addr_b,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr,
    output logic             out_valid,
    output logic [LOG2N-1:0] stage,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WAIT,
        S_UNLOAD
    } state_t;

    localparam logic [LOG2N-1:0] CNT_LAST   = '1;
    localparam logic [LOG2N-2:0] J_LAST     = '1;
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
    localparam logic [2:0]       WAIT_LAST  = 3'(BF_LAT - 1);

    state_t                          state_q, state_d;
    logic [LOG2N-1:0]                cnt_q, cnt_d;
    logic [LOG2N-2:0]                j_q, j_d;
    logic [LOG2N-1:0]                stage_q, stage_d;
    logic [2:0]                      wait_q, wait_d;
    logic                            out_valid_q, out_valid_d;
    logic                            done_q, done_d;
    logic [BF_LAT-1:0]               wbv_q, wbv_d;
    logic [BF_LAT-1:0][LOG2N-1:0]    wba_q, wba_d;
    logic [BF_LAT-1:0][LOG2N-1:0]    wbb_q, wbb_d;

    logic [LOG2N-1:0] jx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] calc_a;
    logic [LOG2N-1:0] calc_b;
    logic [LOG2N-1:0] tw_shift;
    logic [TW_W-1:0]  calc_tw;
    logic [LOG2N-1:0] cnt_rev;

    // Butterfly addressing: insert a zero at bit 'stage' of j to get the upper operand
    always_comb begin
        jx       = {1'b0, j_q};
        half     = LOG2N'(1) << stage_q;
        mask     = half - LOG2N'(1);
        calc_a   = ((jx & ~mask) << 1) | (jx & mask);
        calc_b   = calc_a | half;
        tw_shift = STAGE_LAST - stage_q;
        calc_tw  = TW_W'((jx & mask) << tw_shift);
        cnt_rev  = '0;
        for (int i = 0; i < LOG2N; i++) begin
            cnt_rev[i] = cnt_q[LOG2N-1-i];
        end
    end

    // Output decode from the current state; everything idles at zero
    always_comb begin
        ld_we   = 1'b0;
        ld_addr = '0;
        bf_en   = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        tw_idx  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        stage   = '0;
        busy    = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld_we   = in_valid;
                ld_addr = cnt_rev;
                stage   = stage_q;
                busy    = 1'b1;
            end
            S_CALC: begin
                bf_en   = 1'b1;
                addr_a  = calc_a;
                addr_b  = calc_b;
                tw_idx  = calc_tw;
                stage   = stage_q;
                busy    = 1'b1;
            end
            S_WAIT: begin
                stage   = stage_q;
                busy    = 1'b1;
            end
            S_UNLOAD: begin
                rd_en   = out_ready;
                rd_addr = cnt_q;
                stage   = stage_q;
                busy    = 1'b1;
            end
            default: begin
                busy    = 1'b0;
            end
        endcase
    end

    assign wb_en     = wbv_q[BF_LAT-1];
    assign wb_addr_a = wba_q[BF_LAT-1];
    assign wb_addr_b = wbb_q[BF_LAT-1];
    assign out_valid = out_valid_q;
    assign done      = done_q;

    // Phase sequencing plus the writeback delay line that trails each butterfly
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        j_d         = j_q;
        stage_d     = stage_q;
        wait_d      = wait_q;
        done_d      = 1'b0;
        out_valid_d = rd_en;

        wbv_d    = wbv_q;
        wba_d    = wba_q;
        wbb_d    = wbb_q;
        wbv_d[0] = bf_en;
        wba_d[0] = addr_a;
        wbb_d[0] = addr_b;
        for (int k = 1; k < BF_LAT; k++) begin
            wbv_d[k] = wbv_q[k-1];
            wba_d[k] = wba_q[k-1];
            wbb_d[k] = wbb_q[k-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    j_d     = '0;
                    stage_d = '0;
                    wait_d  = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        stage_d = '0;
                        j_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (j_q == J_LAST) begin
                    state_d = S_WAIT;
                    j_d     = '0;
                    wait_d  = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_UNLOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_CALC;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_UNLOAD: begin
                if (rd_en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts a frame and flushes pending writebacks
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            j_q         <= '0;
            stage_q     <= '0;
            wait_q      <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wbv_q       <= '0;
            wba_q       <= '0;
            wbb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            stage_q     <= stage_d;
            wait_q      <= wait_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            wbv_q       <= wbv_d;
            wba_q       <= wba_d;
            wbb_q       <= wbb_d;
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Testbench for fft_seq_ctrl (N=8, BF_LAT=2): directed vector tables,
// hand-written reset/start corner sequences and randomized frames, all
// compared every cycle against a frame-level reference model.
module tb_fft_seq_ctrl;

    localparam int LOG2N     = 3;
    localparam int BF_LAT    = 2;
    localparam int N         = 8;
    localparam int HALFN     = 4;
    localparam int STAGE_CYC = HALFN + BF_LAT;
    localparam int CALC_CYC  = LOG2N * STAGE_CYC;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic       ld_we, bf_en, wb_en, rd_en, out_valid, busy, done;
    logic [2:0] ld_addr, addr_a, addr_b, wb_addr_a, wb_addr_b, rd_addr, stage;
    logic [1:0] tw_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic st, iv, ordy, chk;
        logic eLdWe;  int eLdAddr;
        logic eBf;    int eA, eB, eTw, eStage;
        logic eRd;    int eRdAddr;
        logic eOv, eDone, eBusy;
    } vec_t;

    vec_t vecs[$];

    int LD_ORDER [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int CALC_A   [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int CALC_B   [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int CALC_TW  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int OR_PAT   [5]  = '{1, 0, 1, 1, 0};

    // Reference model state: frame progress counted in events, not RTL states
    bit mInFrame = 0;
    int mLoads = 0, mCalcT = 0, mRd = 0, obsBf = 0;
    bit mPrevRd = 0, mDone = 0;
    bit histEn [BF_LAT];
    int histA  [BF_LAT];
    int histB  [BF_LAT];
    bit isIdle, isLoad, isCalc, isUnload, eBfNow, eRdNow;
    int eANow, eBNow;

    fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .out_ready(out_ready),
        .ld_we(ld_we), .ld_addr(ld_addr), .bf_en(bf_en), .addr_a(addr_a), .addr_b(addr_b),
        .tw_idx(tw_idx), .wb_en(wb_en), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .out_valid(out_valid), .stage(stage),
        .busy(busy), .done(done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net in case the stimulus ever stops advancing
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int x);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    function automatic vec_t mk(input logic st, input logic iv, input logic ordy);
        vec_t v;
        v.st = st; v.iv = iv; v.ordy = ordy; v.chk = 1'b0;
        v.eLdWe = 1'b0; v.eLdAddr = -1;
        v.eBf = 1'b0; v.eA = 0; v.eB = 0; v.eTw = 0; v.eStage = -1;
        v.eRd = 1'b0; v.eRdAddr = -1;
        v.eOv = 1'b0; v.eDone = 1'b0; v.eBusy = 1'b0;
        return v;
    endfunction

    // Expected outputs for the current cycle, derived from frame progress
    task automatic modelCheck();
        int s, r, half, k, tw;
        isIdle   = !mInFrame;
        isLoad   = mInFrame && (mLoads < N);
        isCalc   = mInFrame && !isLoad && (mCalcT < CALC_CYC);
        isUnload = mInFrame && !isLoad && !isCalc;
        eBfNow = 0; eANow = 0; eBNow = 0; tw = 0;
        if (isCalc) begin
            s = mCalcT / STAGE_CYC;
            r = mCalcT % STAGE_CYC;
            if (r < HALFN) begin
                half   = 1 << s;
                k      = r % half;
                eANow  = (r / half) * 2 * half + k;
                eBNow  = eANow + half;
                tw     = k * (N / (2 * half));
                eBfNow = 1;
            end
            checkOutput("model_stage", 32'(stage), 32'(s));
        end
        eRdNow = isUnload && out_ready;
        checkOutput("model_busy", 32'(busy), 32'(mInFrame));
        checkOutput("model_ld_we", 32'(ld_we), 32'(isLoad && in_valid));
        if (isLoad) checkOutput("model_ld_addr", 32'(ld_addr), 32'(bitrev(mLoads)));
        checkOutput("model_bf_en", 32'(bf_en), 32'(eBfNow));
        if (eBfNow) begin
            checkOutput("model_addr_a", 32'(addr_a), 32'(eANow));
            checkOutput("model_addr_b", 32'(addr_b), 32'(eBNow));
            checkOutput("model_tw_idx", 32'(tw_idx), 32'(tw));
        end
        checkOutput("model_wb_en", 32'(wb_en), 32'(histEn[BF_LAT-1]));
        if (histEn[BF_LAT-1]) begin
            checkOutput("model_wb_addr_a", 32'(wb_addr_a), 32'(histA[BF_LAT-1]));
            checkOutput("model_wb_addr_b", 32'(wb_addr_b), 32'(histB[BF_LAT-1]));
        end
        checkOutput("model_rd_en", 32'(rd_en), 32'(eRdNow));
        if (isUnload) checkOutput("model_rd_addr", 32'(rd_addr), 32'(mRd));
        checkOutput("model_out_valid", 32'(out_valid), 32'(mPrevRd));
        checkOutput("model_done", 32'(done), 32'(mDone));
        if (isIdle)
            checkOutput("model_idle_zero", 32'({ld_addr, addr_a, addr_b, tw_idx, rd_addr, stage}), 32'(0));
        if (bf_en === 1'b1) obsBf++;
    endtask

    // Advance the model across the clock edge
    task automatic modelStep();
        if (rst) begin
            mInFrame = 0; mLoads = 0; mCalcT = 0; mRd = 0;
            mPrevRd = 0; mDone = 0;
            for (int k = 0; k < BF_LAT; k++) begin
                histEn[k] = 0; histA[k] = 0; histB[k] = 0;
            end
            return;
        end
        for (int k = BF_LAT - 1; k > 0; k--) begin
            histEn[k] = histEn[k-1]; histA[k] = histA[k-1]; histB[k] = histB[k-1];
        end
        histEn[0] = eBfNow; histA[0] = eANow; histB[0] = eBNow;
        mDone = isUnload && eRdNow && (mRd == N - 1);
        if (mDone) checkOutput("frame_bf_count", 32'(obsBf), 32'(LOG2N * HALFN));
        mPrevRd = eRdNow;
        if (isIdle && start) begin
            mInFrame = 1; mLoads = 0; mCalcT = 0; mRd = 0; obsBf = 0;
        end else if (isLoad && in_valid) begin
            mLoads++;
        end else if (isCalc) begin
            mCalcT++;
        end else if (isUnload && out_ready) begin
            mRd++;
            if (mRd == N) mInFrame = 0;
        end
    endtask

    task automatic checkRecord(input vec_t v, input int idx);
        checkOutput($sformatf("vec%0d_ld_we", idx), 32'(ld_we), 32'(v.eLdWe));
        if (v.eLdAddr >= 0) checkOutput($sformatf("vec%0d_ld_addr", idx), 32'(ld_addr), 32'(v.eLdAddr));
        checkOutput($sformatf("vec%0d_bf_en", idx), 32'(bf_en), 32'(v.eBf));
        if (v.eBf) begin
            checkOutput($sformatf("vec%0d_addr_a", idx), 32'(addr_a), 32'(v.eA));
            checkOutput($sformatf("vec%0d_addr_b", idx), 32'(addr_b), 32'(v.eB));
            checkOutput($sformatf("vec%0d_tw_idx", idx), 32'(tw_idx), 32'(v.eTw));
        end
        if (v.eStage >= 0) checkOutput($sformatf("vec%0d_stage", idx), 32'(stage), 32'(v.eStage));
        checkOutput($sformatf("vec%0d_rd_en", idx), 32'(rd_en), 32'(v.eRd));
        if (v.eRdAddr >= 0) checkOutput($sformatf("vec%0d_rd_addr", idx), 32'(rd_addr), 32'(v.eRdAddr));
        checkOutput($sformatf("vec%0d_out_valid", idx), 32'(out_valid), 32'(v.eOv));
        checkOutput($sformatf("vec%0d_done", idx), 32'(done), 32'(v.eDone));
        checkOutput($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.eBusy));
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, cross the rising edge
    task automatic applyStimulus(input vec_t v, input logic rs, input int idx);
        start = v.st; in_valid = v.iv; out_ready = v.ordy; rst = rs;
        @(negedge clk);
        modelCheck();
        if (v.chk) checkRecord(v, idx);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Directed frame table: load (optionally with gaps), three stages, handshaked unload
    task automatic buildFrame(input bit gaps, input bit extraStart);
        vec_t v;
        int   k, p;
        logic r, prev;
        vecs.delete();
        v = mk(1, 0, 0); v.chk = 1; v.eLdAddr = 0; vecs.push_back(v);
        for (int i = 0; i < N; i++) begin
            if (gaps && (i == 1 || i == 4)) begin
                v = mk(0, 0, 0); v.chk = 1; v.eLdAddr = LD_ORDER[i]; v.eBusy = 1; vecs.push_back(v);
            end
            v = mk(0, 1, 0); v.chk = 1; v.eLdWe = 1; v.eLdAddr = LD_ORDER[i]; v.eBusy = 1;
            vecs.push_back(v);
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int j = 0; j < HALFN; j++) begin
                v = mk(extraStart && s == 1 && j == 0, 0, 0); v.chk = 1; v.eBf = 1;
                v.eA = CALC_A[s*HALFN+j]; v.eB = CALC_B[s*HALFN+j]; v.eTw = CALC_TW[s*HALFN+j];
                v.eStage = s; v.eBusy = 1; vecs.push_back(v);
            end
            for (int w = 0; w < BF_LAT; w++) begin
                v = mk(0, 0, 0); v.chk = 1; v.eStage = s; v.eBusy = 1; vecs.push_back(v);
            end
        end
        k = 0; p = 0; prev = 0;
        while (k < N) begin
            r = OR_PAT[p % 5][0];
            v = mk(0, 0, r); v.chk = 1; v.eRd = r; v.eRdAddr = k; v.eOv = prev; v.eBusy = 1;
            vecs.push_back(v);
            prev = r;
            if (r) k++;
            p++;
        end
        v = mk(0, 0, 0); v.chk = 1; v.eOv = 1; v.eDone = 1; v.eLdAddr = 0; v.eRdAddr = 0;
        vecs.push_back(v);
    endtask

    task automatic runTable();
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1'b0, i);
    endtask

    initial begin
        int cyc, rstAt;
        for (int k = 0; k < BF_LAT; k++) begin
            histEn[k] = 0; histA[k] = 0; histB[k] = 0;
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(mk(0, 0, 0), 1'b1, -1);
        applyStimulus(mk(1, 1, 1), 1'b1, -1);
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset_done", 32'(done), 32'(0));
        checkOutput("reset_wb_en", 32'(wb_en), 32'(0));

        $display("[TB] frame 1: no stalls on input");
        buildFrame(1'b0, 1'b0);
        runTable();
        applyStimulus(mk(0, 0, 0), 1'b0, -1);

        $display("[TB] frame 2: input gaps and a start pulse during CALC");
        buildFrame(1'b1, 1'b1);
        runTable();

        $display("[TB] reset during stage 1, j=2");
        applyStimulus(mk(1, 0, 0), 1'b0, -1);
        for (int i = 0; i < N; i++) applyStimulus(mk(0, 1, 0), 1'b0, -1);
        for (int i = 0; i < STAGE_CYC + 2; i++) applyStimulus(mk(0, 0, 0), 1'b0, -1);
        checkOutput("pre_reset_addr_a", 32'(addr_a), 32'(4));
        checkOutput("pre_reset_stage", 32'(stage), 32'(1));
        applyStimulus(mk(0, 0, 0), 1'b1, -1);
        checkOutput("post_reset_busy", 32'(busy), 32'(0));
        for (int i = 0; i < BF_LAT + 2; i++) begin
            checkOutput("post_reset_wb_en", 32'(wb_en), 32'(0));
            applyStimulus(mk(0, 0, 0), 1'b0, -1);
        end
        buildFrame(1'b0, 1'b0);
        runTable();

        $display("[TB] randomized frames");
        for (int f = 0; f < 6; f++) begin
            applyStimulus(mk(1, 0, 0), 1'b0, -1);
            cyc   = 0;
            rstAt = (f == 3) ? int'($urandom_range(5, 40)) : -1;
            while (mInFrame && cyc < 400) begin
                applyStimulus(mk($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                                 $urandom_range(0, 2) != 0), cyc == rstAt, -1);
                cyc++;
            end
            checks++;
            if (mInFrame) begin
                failures++;
                $display("[TB] FAIL frame_timeout: frame %0d still busy after %0d cycles, required to finish", f, cyc);
            end
            applyStimulus(mk(0, 0, 0), 1'b0, -1);
            applyStimulus(mk(0, 0, 0), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequencer for the in-place radix-2 DIT FFT core behind tt_um_shinnosuke_fft.
- Runs three phases in order: LOAD, CALC, UNLOAD.
- LOAD writes samples into sample RAM in bit-reversed address order.
- CALC issues one butterfly per cycle with operand addresses and twiddle index, tracks butterfly latency for writeback, and stalls between stages.
- UNLOAD reads results in natural order under a ready handshake.
- Carries no data; drives only RAM/butterfly control.

Parameters:
- LOG2N, 3, log2 of FFT length; N = 2^LOG2N, valid range 2..6.
- BF_LAT, 2, cycles from bf_en to the matching writeback (wb_en), valid range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  input sample present this cycle.
- out_ready  in  1  consumer can accept a result.
- ld_we  out  1  sample RAM write enable (LOAD).
- ld_addr  out  LOG2N  bit-reversed write address.
- bf_en  out  1  issue a butterfly this cycle.
- addr_a  out  LOG2N  butterfly upper operand address.
- addr_b  out  LOG2N  butterfly lower operand address.
- tw_idx  out  LOG2N-1  twiddle ROM index (forced to 1 bit wide when LOG2N=2 would make it width 1).
- wb_en  out  1  write back butterfly results.
- wb_addr_a  out  LOG2N  writeback address for the upper result.
- wb_addr_b  out  LOG2N  writeback address for the lower result.
- rd_en  out  1  result RAM read enable (UNLOAD).
- rd_addr  out  LOG2N  natural-order read address.
- out_valid  out  1  RAM read data valid (1-cycle RAM latency).
- stage  out  LOG2N-bit  current stage index, 0..LOG2N-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- States: IDLE, LOAD, CALC, WAIT, UNLOAD.
- Reset (sync, rst=1): state=IDLE; all counters=0; BF_LAT writeback pipeline cleared; out_valid=0 and done=0 registered.
  - All other outputs decode combinationally to 0 in IDLE.
  - Reset mid-frame aborts immediately. No wb_en occurs after the reset edge.
- IDLE: start=1 -> LOAD with cnt=0. start while busy is ignored.
- LOAD: ld_we = in_valid.
  - ld_addr = bit-reverse of cnt.
  - cnt increments on in_valid.
  - in_valid with cnt=N-1 -> CALC, with stage=0 and j=0.
  - in_valid=0 stalls; there is no timeout.
- CALC: bf_en=1 every cycle; j counts 0..N/2-1.
  - half = 2^stage.
  - addr_a = ((j>>stage) << (stage+1)) | (j & (half-1)).
  - addr_b = addr_a + half.
  - tw_idx = (j & (half-1)) << (LOG2N-1-stage).
  - At j=N/2-1 -> WAIT, with j=0.
- WAIT: bf_en=0 for exactly BF_LAT cycles, so the previous stage's writebacks drain before dependent reads.
  - Then: if stage<LOG2N-1, stage++ and return to CALC; otherwise go to UNLOAD with cnt=0.
- Writeback pipeline: wb_en, wb_addr_a, wb_addr_b equal bf_en, addr_a, addr_b delayed by exactly BF_LAT cycles.
- UNLOAD: rd_en = out_ready; rd_addr = cnt.
  - cnt increments on rd_en.
  - out_valid (registered) = rd_en of the previous cycle.
  - rd_en with cnt=N-1 -> IDLE, and done=1 on the next cycle, coincident with the last out_valid.
- A frame issues LOG2N·N/2 butterflies. With no input or output stalls, CALC+WAIT spans LOG2N·(N/2+BF_LAT) cycles (N=8, BF_LAT=2: 18 cycles).
- ld_we and rd_en depend combinationally on in_valid and out_ready. All other outputs depend only on registered state.

Test Plan:
- Reset then start, N=8, in_valid held high -> ld_addr sequence 0,4,2,6,1,5,3,7; CALC entered on cycle 9 after start.
- CALC stage 0 -> (addr_a,addr_b,tw_idx) = (0,1,0),(2,3,0),(4,5,0),(6,7,0). Stage 1 -> (0,2,0),(1,3,2),(4,6,0),(5,7,2). Stage 2 -> (0,4,0),(1,5,1),(2,6,2),(3,7,3). Exactly 2 bf_en=0 cycles between stages.
- wb_en/wb_addr_a/wb_addr_b mirror bf_en/addr_a/addr_b exactly 2 cycles later. Total bf_en pulses = 12. Last wb_en occurs before the first rd_en.
- UNLOAD with out_ready toggling 1,0,1,1,0,... -> rd_addr 0..7 in order, advancing only when out_ready=1. out_valid lags rd_en by 1 cycle. done pulses once with the 8th out_valid, and busy falls on the same cycle.
- in_valid gaps during LOAD, plus start asserted mid-CALC -> address order unchanged; the extra start has no effect.
- rst asserted mid-CALC (stage 1, j=2) -> next cycle state IDLE, busy=0, no wb_en afterwards. A new start runs a full correct frame.
